iop_mem_arb: RTL and testbench
==============================

Name: iop_mem_arb

Overview:
- Shares one 16-bit memory/bus slave port between two masters.
- M0 is the IOP core load/store port (mem_read/mem_write held until a one-cycle mem_ok). M1 is a secondary master (host or DMA) using the same protocol.
- Arbitrates between the two masters, sequences a single outstanding slave transaction, and returns a one-cycle ok pulse plus read data to the winning master.
- Sits between the IOP core and the shared memory.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with M0 highest.
- TIMEOUT, 255, maximum BUSY cycles without s_ack. Used only when IOP_ARB_TIMEOUT_EN is defined. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_read  in  1  M0 read request (level, held until m0_ok).
- m0_write  in  1  M0 write request (level, held until m0_ok).
- m0_addr  in  AW  M0 address.
- m0_wdata  in  DW  M0 write data.
- m0_ok  out  1  one-cycle completion pulse to M0.
- m0_rdata  out  DW  M0 read data; valid while m0_ok is high, then held.
- m1_read, m1_write, m1_addr, m1_wdata, m1_ok, m1_rdata  same as M0, for M1.
- s_req  out  1  slave request, registered.
- s_we  out  1  slave write enable, registered.
- s_addr  out  AW  slave address, registered.
- s_wdata  out  DW  slave write data, registered.
- s_ack  in  1  slave completion; may be asserted in the first s_req cycle.
- s_rdata  in  DW  slave read data, valid with s_ack.
- owner  out  1  master owning the current transaction (0/1).
- busy  out  1  high in BUSY and RESP states.
- err  out  1  timeout error, pulses with the ok pulse.

Behaviour:
- Reset: rst=1 at a clock edge, including mid-transaction, forces the following:
  - state=IDLE;
  - s_req, s_we, m0_ok, m1_ok, busy, err = 0;
  - s_addr, s_wdata, m0_rdata, m1_rdata = 0;
  - owner=0, last_grant=1 (so M0 wins the first tie);
  - no ok pulse is produced for an aborted transaction.
- Request: mN_req = mN_read | mN_write. If both are high, the access is a write (s_we=1).
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If no request: stay in IDLE.
  - Otherwise pick a winner:
    - PRIO_MODE=0: if both request, grant the master ≠ last_grant; otherwise grant the sole requester.
    - PRIO_MODE=1: M0 whenever it requests.
  - Latch addr, wdata and we from the winner into s_addr/s_wdata/s_we. Set owner=winner, s_req=1, go to BUSY.
- BUSY:
  - s_req and the latched fields stay stable.
  - Master inputs are ignored, even if they drop.
  - On s_ack: s_req←0, capture s_rdata into mOWNER_rdata (captured on writes too; write value is don't-care), go to RESP.
- RESP:
  - mOWNER_ok=1 for exactly this cycle; the other master's ok stays 0.
  - last_grant←owner. Go to IDLE.
  - Requests are not sampled in RESP, so the master's stale request is never re-granted.
- Latency: request sampled in IDLE cycle N → s_req high in N+1 → ok in cycle N+2+W, where W = number of BUSY cycles before s_ack (minimum 0).
- Throughput: at most one transaction per 3 cycles. A second request waits in IDLE (its master stalls).
- mN_rdata holds its value until the next completion to that master.
- busy = (state != IDLE).
- s_ack outside BUSY is ignored.

Optional Feature:
- Macro: IOP_ARB_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter clears on entry to BUSY.
  - If it reaches TIMEOUT without s_ack: s_req←0, mOWNER_rdata←all ones, go to RESP with err=1 alongside the ok pulse.
  - If s_ack arrives in the same cycle as the timeout, s_ack wins (normal completion, err=0).
- Not defined: no counter; BUSY waits indefinitely; err tied 0.

Test Plan:
- M0 read addr 0x0040, slave acks in its first s_req cycle with 0x1234 → s_req high 1 cycle, m0_ok pulses at request+2, m0_rdata=0x1234, m1_ok=0.
- M1 write 0x0100←0xBEEF, slave ack after 3 wait cycles → s_we=1, s_addr=0x0100, s_wdata=0xBEEF held 4 cycles; m1_ok at request+5; owner=1.
- Both masters request every cycle, PRIO_MODE=0 → grants alternate M0,M1,M0,M1 starting with M0; PRIO_MODE=1 → M0 always, M1 starved.
- rst asserted in BUSY → next cycle s_req=0, state IDLE, no ok pulse; after rst release, a pending M1 request is granted normally.
- M0 drops m0_read while BUSY → transaction completes and m0_ok still pulses; m0_read and m0_write both high → s_we=1.
- With IOP_ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks → after 4 BUSY cycles m0_ok=1, err=1, m0_rdata=0xFFFF, s_req=0. Without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/iop_mem_arb.sv
// Two-master arbiter in front of a single 16-bit memory slave: one outstanding transaction at a time.
// Define IOP_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles without s_ack (err pulses with ok).
module iop_mem_arb #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ok,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ok,
  output logic [DW-1:0] m1_rdata,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ack,
  input  logic [DW-1:0] s_rdata,
  output logic          owner,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic   m0_req, m1_req, winner, last_grant, timeout;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;
  assign busy   = (state != IDLE);

  // last_grant resets to 1 so that M0 wins the first round-robin tie
  always_comb begin
    winner = 1'b0;
    if (PRIO_MODE == 1)
      winner = !m0_req;
    else if (m0_req && m1_req)
      winner = !last_grant;
    else
      winner = !m0_req;
  end

`ifdef IOP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] busy_cnt;

  // counter holds zero outside BUSY, so it is clear on every entry to BUSY
  always_ff @(posedge clk) begin
    if (rst || state != BUSY)
      busy_cnt <= '0;
    else
      busy_cnt <= busy_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) && (busy_cnt == CW'(TIMEOUT - 1)) && !s_ack;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m0_req || m1_req) state_nxt = BUSY;
      BUSY:    if (s_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_req      <= 1'b0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      m0_ok      <= 1'b0;
      m1_ok      <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      err        <= 1'b0;
    end else begin
      m0_ok <= 1'b0;
      m1_ok <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner   <= winner;
            s_req   <= 1'b1;
            s_we    <= winner ? m1_write : m0_write;
            s_addr  <= winner ? m1_addr  : m0_addr;
            s_wdata <= winner ? m1_wdata : m0_wdata;
          end
        end
        // an ack arriving together with the timeout is treated as a normal completion
        BUSY: begin
          if (s_ack || timeout) begin
            s_req <= 1'b0;
            if (owner)
              m1_rdata <= s_ack ? s_rdata : '1;
            else
              m0_rdata <= s_ack ? s_rdata : '1;
            m0_ok <= !owner;
            m1_ok <= owner;
            err   <= !s_ack;
          end
        end
        RESP:    last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iop_mem_arb.sv
// Self-checking bench for iop_mem_arb: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model (round-robin and fixed-priority instances).
module tb_iop_mem_arb;

  localparam int TO = 4;
`ifdef IOP_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_read, m0_write, m1_read, m1_write, s_ack;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

  logic        rr_m0_ok, rr_m1_ok, rr_s_req, rr_s_we, rr_owner, rr_busy, rr_err;
  logic [15:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic        fp_m0_ok, fp_m1_ok, fp_s_req, fp_s_we, fp_owner, fp_busy, fp_err;
  logic [15:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iop_mem_arb #(.AW(16), .DW(16), .PRIO_MODE(0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ok(rr_m0_ok), .m0_rdata(rr_m0_rdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ok(rr_m1_ok), .m1_rdata(rr_m1_rdata),
    .s_req(rr_s_req), .s_we(rr_s_we), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .owner(rr_owner), .busy(rr_busy), .err(rr_err)
  );

  iop_mem_arb #(.AW(16), .DW(16), .PRIO_MODE(1), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ok(fp_m0_ok), .m0_rdata(fp_m0_rdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ok(fp_m1_ok), .m1_rdata(fp_m1_rdata),
    .s_req(fp_s_req), .s_we(fp_s_we), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .owner(fp_owner), .busy(fp_busy), .err(fp_err)
  );

  typedef struct {
    logic rst, m0r, m0w; logic [15:0] m0a, m0d;
    logic m1r, m1w;      logic [15:0] m1a, m1d;
    logic ack;           logic [15:0] srd;
    logic e_sreq, e_swe; logic [15:0] e_saddr, e_swdata;
    logic e_busy, e_own, e_ok0, e_ok1; logic [15:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vec[10];

  // transaction-level reference model state, one slot per instance (0 = round-robin, 1 = fixed)
  bit          m_act[2], m_resp[2], m_own[2], m_last[2], m_sreq[2], m_we[2];
  bit          m_ok0[2], m_ok1[2], m_err[2];
  int          m_wait[2];
  logic [15:0] m_addr[2], m_wd[2], m_rd0[2], m_rd1[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    m0_read = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
    m1_read = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
    s_ack = 0; s_rdata = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    m0_read = v.m0r; m0_write = v.m0w; m0_addr = v.m0a; m0_wdata = v.m0d;
    m1_read = v.m1r; m1_write = v.m1w; m1_addr = v.m1a; m1_wdata = v.m1d;
    s_ack = v.ack; s_rdata = v.srd;
  endtask

  task automatic modelStep(input int k);
    bit r0, r1, w, fin, fin_err;
    logic [15:0] val;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    fin = 0; fin_err = 0; val = 0;
    if (rst) begin
      m_act[k] = 0; m_resp[k] = 0; m_own[k] = 0; m_last[k] = 1; m_sreq[k] = 0; m_we[k] = 0;
      m_ok0[k] = 0; m_ok1[k] = 0; m_err[k] = 0; m_wait[k] = 0;
      m_addr[k] = 0; m_wd[k] = 0; m_rd0[k] = 0; m_rd1[k] = 0;
    end else if (m_resp[k]) begin
      m_resp[k] = 0; m_ok0[k] = 0; m_ok1[k] = 0; m_err[k] = 0;
      m_last[k] = m_own[k];
    end else if (m_act[k]) begin
      m_wait[k]++;
      if (s_ack) begin
        fin = 1; val = s_rdata;
      end else if (TO_EN && m_wait[k] == TO) begin
        fin = 1; fin_err = 1; val = 16'hFFFF;
      end
      if (fin) begin
        m_act[k] = 0; m_resp[k] = 1; m_sreq[k] = 0; m_err[k] = fin_err;
        if (m_own[k]) begin m_rd1[k] = val; m_ok1[k] = 1; end
        else          begin m_rd0[k] = val; m_ok0[k] = 1; end
      end
    end else if (r0 || r1) begin
      if (r0 && r1) w = (k == 1) ? 1'b0 : !m_last[k];
      else          w = r1;
      m_own[k]  = w;
      m_addr[k] = w ? m1_addr : m0_addr;
      m_wd[k]   = w ? m1_wdata : m0_wdata;
      m_we[k]   = w ? m1_write : m0_write;
      m_act[k] = 1; m_sreq[k] = 1; m_wait[k] = 0;
    end
  endtask

  task automatic checkInst(input string p, input int k,
                           input logic sreq, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd, input logic bsy, input logic own,
                           input logic ok0, input logic ok1, input logic e,
                           input logic [15:0] rd0, input logic [15:0] rd1);
    checkOutput({p, " s_req"},    sreq, m_sreq[k]);
    checkOutput({p, " s_we"},     we,   m_we[k]);
    checkOutput({p, " s_addr"},   addr, m_addr[k]);
    checkOutput({p, " s_wdata"},  wd,   m_wd[k]);
    checkOutput({p, " busy"},     bsy,  m_act[k] | m_resp[k]);
    checkOutput({p, " owner"},    own,  m_own[k]);
    checkOutput({p, " m0_ok"},    ok0,  m_ok0[k]);
    checkOutput({p, " m1_ok"},    ok1,  m_ok1[k]);
    checkOutput({p, " err"},      e,    m_err[k]);
    checkOutput({p, " m0_rdata"}, rd0,  m_rd0[k]);
    checkOutput({p, " m1_rdata"}, rd1,  m_rd1[k]);
  endtask

  initial begin
    bit mp[2];
    int kind[2];

    rst = 1;
    clearInputs();

    // M0 read with zero-wait ack, then M1 write with three wait cycles
    vec[0] = '{1,0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,16'h0,    0,0,16'h0,16'h0,0,0,0,0,16'h0,16'h0};
    vec[1] = '{0,1,0,16'h40,16'h0, 0,0,16'h0,16'h0, 0,16'h0,   1,0,16'h40,16'h0,1,0,0,0,16'h0,16'h0};
    vec[2] = '{0,1,0,16'h40,16'h0, 0,0,16'h0,16'h0, 1,16'h1234,0,0,16'h40,16'h0,1,0,1,0,16'h1234,16'h0};
    vec[3] = '{0,1,0,16'h40,16'h0, 0,0,16'h0,16'h0, 0,16'h0,   0,0,16'h40,16'h0,0,0,0,0,16'h1234,16'h0};
    vec[4] = '{0,0,0,16'h0,16'h0, 0,1,16'h100,16'hBEEF, 1,16'h9999, 1,1,16'h100,16'hBEEF,1,1,0,0,16'h1234,16'h0};
    vec[5] = '{0,0,0,16'h0,16'h0, 0,1,16'h100,16'hBEEF, 0,16'h0, 1,1,16'h100,16'hBEEF,1,1,0,0,16'h1234,16'h0};
    vec[6] = vec[5];
    vec[7] = vec[5];
    vec[8] = '{0,0,0,16'h0,16'h0, 0,1,16'h100,16'hBEEF, 1,16'h5555, 0,1,16'h100,16'hBEEF,1,1,0,1,16'h1234,16'h5555};
    vec[9] = '{0,0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,16'h0, 0,1,16'h100,16'hBEEF,0,1,0,0,16'h1234,16'h5555};

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vec[i]);
      step();
      checkOutput($sformatf("vec%0d s_req", i),    rr_s_req,    vec[i].e_sreq);
      checkOutput($sformatf("vec%0d s_we", i),     rr_s_we,     vec[i].e_swe);
      checkOutput($sformatf("vec%0d s_addr", i),   rr_s_addr,   vec[i].e_saddr);
      checkOutput($sformatf("vec%0d s_wdata", i),  rr_s_wdata,  vec[i].e_swdata);
      checkOutput($sformatf("vec%0d busy", i),     rr_busy,     vec[i].e_busy);
      checkOutput($sformatf("vec%0d owner", i),    rr_owner,    vec[i].e_own);
      checkOutput($sformatf("vec%0d m0_ok", i),    rr_m0_ok,    vec[i].e_ok0);
      checkOutput($sformatf("vec%0d m1_ok", i),    rr_m1_ok,    vec[i].e_ok1);
      checkOutput($sformatf("vec%0d m0_rdata", i), rr_m0_rdata, vec[i].e_rd0);
      checkOutput($sformatf("vec%0d m1_rdata", i), rr_m1_rdata, vec[i].e_rd1);
      checkOutput($sformatf("vec%0d fp s_req", i), fp_s_req,    vec[i].e_sreq);
      checkOutput($sformatf("vec%0d fp m1_ok", i), fp_m1_ok,    vec[i].e_ok1);
    end

    $display("[TB] arbitration with both masters requesting continuously");
    rst = 1; clearInputs(); step(); rst = 0;
    m0_read = 1; m0_addr = 16'hA000; m1_read = 1; m1_addr = 16'hB000;
    s_ack = 1; s_rdata = 16'hC0DE;
    for (int t = 0; t < 4; t++) begin
      step();
      checkOutput($sformatf("arb%0d rr owner", t), rr_owner, t % 2);
      checkOutput($sformatf("arb%0d rr s_addr", t), rr_s_addr, (t % 2) ? 16'hB000 : 16'hA000);
      checkOutput($sformatf("arb%0d fp owner", t), fp_owner, 0);
      checkOutput($sformatf("arb%0d rr s_req", t), rr_s_req, 1);
      step();
      checkOutput($sformatf("arb%0d rr m0_ok", t), rr_m0_ok, (t % 2) == 0);
      checkOutput($sformatf("arb%0d rr m1_ok", t), rr_m1_ok, (t % 2) == 1);
      checkOutput($sformatf("arb%0d fp m0_ok", t), fp_m0_ok, 1);
      checkOutput($sformatf("arb%0d fp m1_ok", t), fp_m1_ok, 0);
      step();
    end

    $display("[TB] reset while BUSY");
    clearInputs();
    m1_read = 1; m1_addr = 16'h0222;
    step();
    checkOutput("rstbusy grant s_req", rr_s_req, 1);
    checkOutput("rstbusy grant owner", rr_owner, 1);
    rst = 1; s_ack = 1; s_rdata = 16'h7777;
    step();
    checkOutput("rstbusy s_req", rr_s_req, 0);
    checkOutput("rstbusy busy", rr_busy, 0);
    checkOutput("rstbusy m1_ok", rr_m1_ok, 0);
    checkOutput("rstbusy m1_rdata", rr_m1_rdata, 0);
    rst = 0; s_ack = 0;
    step();
    checkOutput("rstbusy after m1_ok", rr_m1_ok, 0);
    checkOutput("rstbusy regrant s_req", rr_s_req, 1);
    checkOutput("rstbusy regrant owner", rr_owner, 1);
    s_ack = 1;
    step();
    checkOutput("rstbusy done m1_ok", rr_m1_ok, 1);
    checkOutput("rstbusy done m1_rdata", rr_m1_rdata, 16'h7777);
    clearInputs();
    step();

    $display("[TB] read+write request dropped while BUSY");
    m0_read = 1; m0_write = 1; m0_addr = 16'h0333; m0_wdata = 16'h4444;
    step();
    checkOutput("drop s_we", rr_s_we, 1);
    checkOutput("drop s_wdata", rr_s_wdata, 16'h4444);
    m0_read = 0; m0_write = 0; m0_addr = 16'h0; m0_wdata = 16'h0;
    step();
    checkOutput("drop held s_req", rr_s_req, 1);
    checkOutput("drop held s_addr", rr_s_addr, 16'h0333);
    s_ack = 1; s_rdata = 16'h0101;
    step();
    checkOutput("drop m0_ok", rr_m0_ok, 1);
    checkOutput("drop m0_rdata", rr_m0_rdata, 16'h0101);
    checkOutput("drop m1_ok", rr_m1_ok, 0);
    s_ack = 0;
    step();
    checkOutput("drop ok cleared", rr_m0_ok, 0);
    checkOutput("drop idle busy", rr_busy, 0);

    $display("[TB] slave never acknowledges");
    m0_read = 1; m0_addr = 16'h0555;
    step();
`ifdef IOP_ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      checkOutput($sformatf("tmo wait%0d s_req", i), rr_s_req, 1);
      checkOutput($sformatf("tmo wait%0d m0_ok", i), rr_m0_ok, 0);
      step();
    end
    checkOutput("tmo m0_ok", rr_m0_ok, 1);
    checkOutput("tmo err", rr_err, 1);
    checkOutput("tmo m0_rdata", rr_m0_rdata, 16'hFFFF);
    checkOutput("tmo s_req", rr_s_req, 0);
    m0_read = 0;
    step();
    checkOutput("tmo err cleared", rr_err, 0);
    checkOutput("tmo idle busy", rr_busy, 0);
`else
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("noack wait%0d busy", i), rr_busy, 1);
      checkOutput($sformatf("noack wait%0d m0_ok", i), rr_m0_ok, 0);
      checkOutput($sformatf("noack wait%0d err", i), rr_err, 0);
      step();
    end
    m0_read = 0;
`endif

    $display("[TB] randomized run against reference model");
    rst = 1; clearInputs(); step();
    modelStep(0); modelStep(1);
    mp[0] = 0; mp[1] = 0; kind[0] = 0; kind[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      s_ack = ($urandom_range(0, 9) < 4);
      s_rdata = 16'($urandom);
      if (!mp[0] && $urandom_range(0, 2) == 0) begin
        mp[0] = 1; kind[0] = $urandom_range(1, 3);
        m0_addr = 16'($urandom); m0_wdata = 16'($urandom);
      end
      if (!mp[1] && $urandom_range(0, 2) == 0) begin
        mp[1] = 1; kind[1] = $urandom_range(1, 3);
        m1_addr = 16'($urandom); m1_wdata = 16'($urandom);
      end
      m0_read  = mp[0] && kind[0][0];
      m0_write = mp[0] && kind[0][1];
      m1_read  = mp[1] && kind[1][0];
      m1_write = mp[1] && kind[1][1];
      step();
      modelStep(0);
      modelStep(1);
      checkInst("rnd rr", 0, rr_s_req, rr_s_we, rr_s_addr, rr_s_wdata, rr_busy, rr_owner,
                rr_m0_ok, rr_m1_ok, rr_err, rr_m0_rdata, rr_m1_rdata);
      checkInst("rnd fp", 1, fp_s_req, fp_s_we, fp_s_addr, fp_s_wdata, fp_busy, fp_owner,
                fp_m0_ok, fp_m1_ok, fp_err, fp_m0_rdata, fp_m1_rdata);
      if (rr_m0_ok) mp[0] = 0;
      if (rr_m1_ok) mp[1] = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
